// File: rtl/enet_pkg.sv
// Shared Ethernet constants and the TX CRC state encoding, used by the TX FCS
// appender and later by the RX FCS checker.
package enet_pkg;

    localparam logic [31:0] ENET_CRC_POLY_R  = 32'hEDB8_8320;
    localparam logic [31:0] ENET_CRC_INIT    = 32'hFFFF_FFFF;
    // Remainder left in the reflected register after a good frame plus its FCS
    // (unreflected form 32'hC704_DD7B).
    localparam logic [31:0] ENET_CRC_RESIDUE = 32'hDEBB_20E3;
    localparam int          ENET_MIN_NIBBLES = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/enet_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, data LSB first.
// Four bit steps unrolled; shared by the TX appender and the RX checker.
module enet_crc32_nibble
    import enet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] s1, s2, s3;

    assign s1      = {1'b0, crc_in[31:1]} ^ ({32{crc_in[0] ^ d[0]}} & ENET_CRC_POLY_R);
    assign s2      = {1'b0, s1[31:1]}     ^ ({32{s1[0]     ^ d[1]}} & ENET_CRC_POLY_R);
    assign s3      = {1'b0, s2[31:1]}     ^ ({32{s2[0]     ^ d[2]}} & ENET_CRC_POLY_R);
    assign crc_out = {1'b0, s3[31:1]}     ^ ({32{s3[0]     ^ d[3]}} & ENET_CRC_POLY_R);

endmodule

// File: rtl/enet_txcrc.sv
// TX nibble-stream FCS appender: passes the frame through and appends ~CRC-32,
// low nibble first. Define ENET_TXCRC_PAD_EN to zero-pad short frames to MINNIBBLES.
module enet_txcrc
    import enet_pkg::*;
#(
    parameter int MINNIBBLES = ENET_MIN_NIBBLES
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_cancel,
    input  logic       i_v,
    input  logic [3:0] i_d,
    output logic       o_v,
    output logic [3:0] o_d
);

    tx_state_t   state, state_nx;
    logic [31:0] crc, crc_nx, crc_src, crc_upd, fcs;
    logic [3:0]  d_src;
    logic [2:0]  idx, idx_nx;
    logic        en_latched, en_nx;
    logic        ov_nx;
    logic [3:0]  od_nx;

`ifdef ENET_TXCRC_PAD_EN
    localparam int                CNT_W   = $clog2(MINNIBBLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MINNIBBLES);
    logic [CNT_W-1:0] count, count_nx;
`else
    logic unused_minnibbles;
    assign unused_minnibbles = ^MINNIBBLES;
`endif

    // A new frame folds its first nibble into a fresh init value; padding folds zeros.
    assign crc_src = (state == IDLE) ? ENET_CRC_INIT : crc;
    assign d_src   = (state == IDLE || state == DATA) ? i_d : 4'h0;
    assign fcs     = ~crc;

    enet_crc32_nibble u_crc (
        .crc_in  (crc_src),
        .d       (d_src),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_nx = state;
        crc_nx   = crc;
        idx_nx   = idx;
        en_nx    = en_latched;
        ov_nx    = 1'b0;
        od_nx    = 4'h0;
`ifdef ENET_TXCRC_PAD_EN
        count_nx = count;
`endif
        if (i_cancel) begin
            state_nx = IDLE;
            crc_nx   = ENET_CRC_INIT;
            idx_nx   = 3'd0;
`ifdef ENET_TXCRC_PAD_EN
            count_nx = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    crc_nx = ENET_CRC_INIT;
`ifdef ENET_TXCRC_PAD_EN
                    count_nx = '0;
`endif
                    if (i_v) begin
                        en_nx    = i_en;
                        ov_nx    = 1'b1;
                        od_nx    = i_d;
                        crc_nx   = crc_upd;
                        state_nx = DATA;
`ifdef ENET_TXCRC_PAD_EN
                        count_nx = CNT_W'(1);
`endif
                    end
                end
                DATA: begin
                    if (i_v) begin
                        ov_nx  = 1'b1;
                        od_nx  = i_d;
                        crc_nx = crc_upd;
`ifdef ENET_TXCRC_PAD_EN
                        if (count < CNT_MAX) count_nx = count + CNT_W'(1);
`endif
                    end else if (!en_latched) begin
                        state_nx = IDLE;
`ifdef ENET_TXCRC_PAD_EN
                    end else if (count < CNT_MAX) begin
                        ov_nx    = 1'b1;
                        crc_nx   = crc_upd;
                        count_nx = count + CNT_W'(1);
                        state_nx = PAD;
`endif
                    end else begin
                        // First FCS nibble goes out on the cycle i_v drops: no gap.
                        ov_nx    = 1'b1;
                        od_nx    = fcs[3:0];
                        idx_nx   = 3'd1;
                        state_nx = FCS;
                    end
                end
                PAD: begin
`ifdef ENET_TXCRC_PAD_EN
                    ov_nx = 1'b1;
                    if (count < CNT_MAX) begin
                        crc_nx   = crc_upd;
                        count_nx = count + CNT_W'(1);
                    end else begin
                        od_nx    = fcs[3:0];
                        idx_nx   = 3'd1;
                        state_nx = FCS;
                    end
`else
                    state_nx = IDLE;
`endif
                end
                FCS: begin
                    ov_nx  = 1'b1;
                    od_nx  = fcs[{idx, 2'b00} +: 4];
                    idx_nx = idx + 3'd1;
                    if (idx == 3'd7) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            crc        <= ENET_CRC_INIT;
            idx        <= 3'd0;
            en_latched <= 1'b0;
            o_v        <= 1'b0;
            o_d        <= 4'h0;
`ifdef ENET_TXCRC_PAD_EN
            count      <= '0;
`endif
        end else if (i_ce) begin
            state      <= state_nx;
            crc        <= crc_nx;
            idx        <= idx_nx;
            en_latched <= en_nx;
            o_v        <= ov_nx;
            o_d        <= od_nx;
`ifdef ENET_TXCRC_PAD_EN
            count      <= count_nx;
`endif
        end
    end

endmodule

// File: tb/tb_enet_txcrc.sv
// Self-checking bench for enet_txcrc: table-driven frames, hand-written corner
// sequences and random frames against a byte-level CRC-32 reference model.
module tb_enet_txcrc;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       s;
        bit          en;
        bit          toggle;
        int          per;
        logic [31:0] fcs;
    } vec_t;

    localparam logic [31:0] POLY = 32'hEDB8_8320;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_ce = 1'b0;
    logic       i_en = 1'b0;
    logic       i_cancel = 1'b0;
    logic       i_v = 1'b0;
    logic [3:0] i_d = 4'h0;
    logic       o_v;
    logic [3:0] o_d;

    int n_pass = 0;
    int n_chk  = 0;

    logic       s_v[$];
    logic [3:0] s_d[$];
    logic       s_en[$];
    logic       s_cn[$];
    logic       e_v[$];
    logic [3:0] e_d[$];
    logic [3:0] cap[$];

    vec_t tbl[5];

    always #5 i_clk = ~i_clk;

    enet_txcrc dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_en      (i_en),
        .i_cancel  (i_cancel),
        .i_v       (i_v),
        .i_d       (i_d),
        .o_v       (o_v),
        .o_d       (o_d)
    );

    // Reference CRC-32 over whole bytes (register value before final inversion).
    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clear_seq();
        s_v.delete(); s_d.delete(); s_en.delete(); s_cn.delete();
        e_v.delete(); e_d.delete();
    endtask

    task automatic add_idle(input int n);
        for (int j = 0; j < n; j++) begin
            s_v.push_back(1'b0); s_d.push_back(4'($urandom)); s_en.push_back(1'($urandom));
            s_cn.push_back(1'b0); e_v.push_back(1'b0); e_d.push_back(4'h0);
        end
    endtask

    // Appends one frame plus its idle gap to the stimulus and the expected stream.
    task automatic add_frame(input bq_t b, input bit en, input bit toggle, input int gap);
        bq_t         p;
        logic [3:0]  tail[$];
        logic [3:0]  nib;
        logic [31:0] f;
        int          n_idle;
        p = b;
`ifdef ENET_TXCRC_PAD_EN
        if (en) while (p.size() < 60) p.push_back(8'h00);
`endif
        foreach (b[i]) begin
            for (int h = 0; h < 2; h++) begin
                nib = (h == 0) ? b[i][3:0] : b[i][7:4];
                s_v.push_back(1'b1); s_d.push_back(nib);
                s_en.push_back((toggle && !(i == 0 && h == 0)) ? !en : en);
                s_cn.push_back(1'b0); e_v.push_back(1'b1); e_d.push_back(nib);
            end
        end
        if (en) begin
            for (int i = b.size(); i < p.size(); i++) begin
                tail.push_back(4'h0); tail.push_back(4'h0);
            end
            f = ~crc32(p);
            for (int j = 0; j < 8; j++) tail.push_back(f[4*j +: 4]);
        end
        n_idle = (gap > tail.size()) ? gap : tail.size();
        for (int j = 0; j < n_idle; j++) begin
            s_v.push_back(1'b0); s_d.push_back(4'($urandom)); s_en.push_back(1'($urandom));
            s_cn.push_back(1'b0);
            e_v.push_back(j < tail.size());
            e_d.push_back((j < tail.size()) ? tail[j] : 4'h0);
        end
    endtask

    task automatic apply_cancel(input int c);
        s_cn[c] = 1'b1;
        for (int k = c; k < e_v.size() && (k == c || s_v[k] == 1'b0); k++) begin
            e_v[k] = 1'b0; e_d[k] = 4'h0;
        end
    endtask

    // One ce cycle per stimulus entry, with per-1 dead cycles of random junk between.
    task automatic run_seq(input string name, input int per);
        int         bad, first, unstable, nv, env;
        logic       lv;
        logic [3:0] ld;
        bad = 0; first = -1; unstable = 0; nv = 0; env = 0;
        cap.delete();
        @(negedge i_clk);
        for (int k = 0; k < s_v.size(); k++) begin
            i_ce = 1'b1; i_v = s_v[k]; i_d = s_d[k]; i_en = s_en[k]; i_cancel = s_cn[k];
            @(negedge i_clk);
            if (o_v === 1'b1) begin nv++; cap.push_back(o_d); end
            if (e_v[k]) env++;
            if (o_v !== e_v[k] || (e_v[k] && o_d !== e_d[k])) begin
                bad++;
                if (first < 0) first = k;
            end
            lv = o_v; ld = o_d;
            for (int w = 1; w < per; w++) begin
                i_ce = 1'b0; i_v = 1'($urandom); i_d = 4'($urandom);
                i_en = 1'($urandom); i_cancel = 1'($urandom);
                @(negedge i_clk);
                if (o_v !== lv || o_d !== ld) unstable++;
            end
        end
        i_ce = 1'b0; i_v = 1'b0; i_cancel = 1'b0;
        check($sformatf("%s_stream(bad_entries,first_idx=%0d)", name, first), bad, 0);
        check({name, "_ov_count"}, nv, env);
        if (per > 1) check({name, "_ce_hold"}, unstable, 0);
    endtask

    task automatic check_fcs(input string name, input logic [31:0] exp);
        logic [31:0] f;
        int          n;
        f = 32'h0;
        n = cap.size();
        if (n >= 8) for (int j = 0; j < 8; j++) f[4*j +: 4] = cap[n-8+j];
        check({name, "_fcs"}, f, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t q;
        int  nfr, len;

        tbl[0] = '{"123456789", 1'b1, 1'b0, 1, 32'hCBF4_3926};
        tbl[1] = '{"123456789", 1'b0, 1'b1, 1, 32'h0};
        tbl[2] = '{"123456789", 1'b1, 1'b0, 4, 32'hCBF4_3926};
        tbl[3] = '{"abc",       1'b1, 1'b0, 2, 32'h3524_41C2};
        tbl[4] = '{"a",         1'b1, 1'b1, 1, 32'hE8B7_BE43};

        // Reset holds outputs low even with ce and valid asserted.
        i_ce = 1'b1; i_v = 1'b1; i_d = 4'hF;
        repeat (3) @(negedge i_clk);
        check("reset_ov", o_v, 1'b0);
        check("reset_od", o_d, 4'h0);
        i_ce = 1'b0; i_v = 1'b0;
        i_reset_n = 1'b1;

        foreach (tbl[t]) begin
            clear_seq();
            add_idle(2);
            add_frame(s2q(tbl[t].s), tbl[t].en, tbl[t].toggle, 8);
            run_seq($sformatf("tbl%0d", t), tbl[t].per);
`ifndef ENET_TXCRC_PAD_EN
            if (tbl[t].en) check_fcs($sformatf("tbl%0d", t), tbl[t].fcs);
`endif
        end

        // Cancel mid-FCS, then a clean frame must still carry the right FCS.
        clear_seq();
        add_idle(1);
        add_frame(s2q("123456789"), 1'b1, 1'b0, 8);
        apply_cancel(1 + 18 + 3);
        add_frame(s2q("123456789"), 1'b1, 1'b0, 8);
        run_seq("cancel", 1);
`ifndef ENET_TXCRC_PAD_EN
        check_fcs("cancel_next", 32'hCBF4_3926);
`endif

        // Back-to-back frames separated by exactly the FCS-length gap.
        clear_seq();
        add_idle(1);
        add_frame(s2q("123456789"), 1'b1, 1'b0, 8);
        add_frame(s2q("abc"), 1'b1, 1'b0, 8);
        run_seq("b2b", 1);
`ifndef ENET_TXCRC_PAD_EN
        check_fcs("b2b_second", 32'h3524_41C2);
`endif

        // Asynchronous reset in the middle of DATA.
        @(negedge i_clk);
        i_ce = 1'b1; i_en = 1'b1; i_cancel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_v = 1'b1; i_d = 4'(k + 1);
            @(negedge i_clk);
        end
        check("pre_reset_ov", o_v, 1'b1);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_reset_ov", o_v, 1'b0);
        check("async_reset_od", o_d, 4'h0);
        @(negedge i_clk);
        i_v = 1'b0; i_ce = 1'b0;
        i_reset_n = 1'b1;
        clear_seq();
        add_idle(1);
        add_frame(s2q("123456789"), 1'b1, 1'b0, 8);
        run_seq("post_reset", 1);
`ifndef ENET_TXCRC_PAD_EN
        check_fcs("post_reset", 32'hCBF4_3926);
`endif

`ifdef ENET_TXCRC_PAD_EN
        clear_seq();
        add_idle(1);
        q.delete(); q.push_back(8'hA5);
        add_frame(q, 1'b1, 1'b0, 8);
        run_seq("pad", 1);
        check("pad_len", cap.size(), 128);
`endif

        // Random frames, random enables, gaps and clock-enable ratios.
        for (int r = 0; r < 6; r++) begin
            clear_seq();
            add_idle(1);
            nfr = 1 + int'($urandom_range(2, 0));
            for (int f = 0; f < nfr; f++) begin
                q.delete();
                len = 1 + int'($urandom_range(23, 0));
                for (int i = 0; i < len; i++) q.push_back(8'($urandom));
                add_frame(q, 1'($urandom), 1'($urandom), 8 + int'($urandom_range(3, 0)));
            end
            run_seq($sformatf("rnd%0d", r), 1 + int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
